// File: rtl/run_monitor_pkg.sv
// Shared types and helpers for the run_monitor supervisor.
package run_monitor_pkg;

    // Supervisor states; encodings are fixed so they can be observed externally.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    // Widest counter the all-ones helper can describe.
    localparam int unsigned MAX_CNT_W = 64;

    // All-ones value for a counter of width w, right-aligned in 64 bits.
    function automatic logic [MAX_CNT_W-1:0] all_ones(input int unsigned w);
        logic [MAX_CNT_W-1:0] v;
        if (w >= MAX_CNT_W) begin
            v = '1;
        end else begin
            v = (64'd1 << w) - 64'd1;
        end
        return v;
    endfunction

    // Width of the hold counter: clog2(HOLD_CYCLES+1), never below 1.
    function automatic int unsigned hold_cnt_w(input int unsigned hold_cycles);
        int unsigned w;
        w = $clog2(hold_cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: synchronous clear, increments on inc, sticks at all-ones.
module sat_counter
    import run_monitor_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ALL_ONES = W'(all_ones(W));

    // Count up on inc, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != ALL_ONES)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run supervisor: holds the downstream DUT in reset for HOLD_CYCLES, then
// counts run cycles and per-channel events, ending in DONE (all targets met)
// or TIMEOUT (cycle budget spent). Optional LED heartbeat is enabled by
// defining RUN_MONITOR_HEARTBEAT_EN; otherwise heartbeat is tied low.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned CYC_W         = 24,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned MAX_CYCLES    = 30000,
    parameter int unsigned HEARTBEAT_DIV = 6000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       event_i,
    input  logic [N_CH*CNT_W-1:0] target_i,
    output logic                  dut_reset,
    output logic                  running,
    output logic                  done,
    output logic                  timeout,
    output logic [CYC_W-1:0]      cycle_count,
    output logic [N_CH*CNT_W-1:0] event_count,
    output logic [N_CH-1:0]       chan_done,
    output logic                  heartbeat
);

    localparam int unsigned       HOLD_W    = hold_cnt_w(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(all_ones(CNT_W));
    localparam logic [CYC_W-1:0]  CYC_MAX   = CYC_W'(all_ones(CYC_W));
    localparam logic [CYC_W-1:0]  CYC_LIMIT = CYC_W'(MAX_CYCLES);

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_dut_reset;
    logic                r_running;
    logic                r_done;
    logic                r_timeout;

    logic                  w_in_run;
    logic                  w_cnt_clr;
    logic [N_CH-1:0]       w_evt_inc;
    logic [CYC_W-1:0]      w_cyc_nxt;
    logic [N_CH*CNT_W-1:0] w_evt_nxt;
    logic [N_CH-1:0]       w_chan_done_nxt;
    logic                  w_all_done_nxt;
    logic                  w_budget_hit;

    assign w_in_run  = (r_state == RUN);
    assign w_cnt_clr = (r_state == HOLD);
    assign w_evt_inc = w_in_run ? event_i : '0;

    sat_counter #(.W(CYC_W)) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_cnt_clr),
        .inc   (w_in_run),
        .q     (cycle_count)
    );

    for (genvar g = 0; g < N_CH; g++) begin : g_evt
        sat_counter #(.W(CNT_W)) u_evt_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (w_cnt_clr),
            .inc   (w_evt_inc[g]),
            .q     (event_count[g*CNT_W +: CNT_W])
        );
    end

    // Predict the counter values after this edge so exits see the final count;
    // also derive the per-channel done flags from the registered counts.
    always_comb begin
        w_cyc_nxt       = cycle_count;
        w_evt_nxt       = event_count;
        w_chan_done_nxt = '0;
        chan_done       = '0;
        if (w_in_run && (cycle_count != CYC_MAX)) begin
            w_cyc_nxt = cycle_count + CYC_W'(1);
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_evt_inc[i] && (event_count[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                w_evt_nxt[i*CNT_W +: CNT_W] = event_count[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
            w_chan_done_nxt[i] = (w_evt_nxt[i*CNT_W +: CNT_W] >= target_i[i*CNT_W +: CNT_W]);
            chan_done[i]       = (event_count[i*CNT_W +: CNT_W] >= target_i[i*CNT_W +: CNT_W]);
        end
        w_all_done_nxt = &w_chan_done_nxt;
        w_budget_hit   = (w_cyc_nxt >= CYC_LIMIT);
    end

    // Supervisor FSM with registered status outputs; DONE takes priority over TIMEOUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HOLD;
            r_hold      <= '0;
            r_dut_reset <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state     <= RUN;
                        r_dut_reset <= 1'b0;
                        r_running   <= 1'b1;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (w_all_done_nxt) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (w_budget_hit) begin
                        r_state   <= TIMEOUT;
                        r_running <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                DONE, TIMEOUT: begin
                end
                default: begin
                    r_state <= HOLD;
                end
            endcase
        end
    end

    assign dut_reset = r_dut_reset;
    assign running   = r_running;
    assign done      = r_done;
    assign timeout   = r_timeout;

`ifdef RUN_MONITOR_HEARTBEAT_EN
    localparam int unsigned     HB_W         = $clog2(HEARTBEAT_DIV + 1);
    localparam int unsigned     HB_FAST      = (HEARTBEAT_DIV / 4 > 0) ? HEARTBEAT_DIV / 4 : 1;
    localparam logic [HB_W-1:0] HB_RUN_LAST  = HB_W'(HEARTBEAT_DIV - 1);
    localparam logic [HB_W-1:0] HB_FAST_LAST = HB_W'(HB_FAST - 1);

    logic [HB_W-1:0] r_hb_div;
    logic            r_heartbeat;

    // LED heartbeat: slow blink in RUN, solid in DONE, fast blink in TIMEOUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hb_div    <= '0;
            r_heartbeat <= 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    r_hb_div    <= '0;
                    r_heartbeat <= 1'b0;
                end
                RUN: begin
                    if (r_hb_div >= HB_RUN_LAST) begin
                        r_hb_div    <= '0;
                        r_heartbeat <= ~r_heartbeat;
                    end else begin
                        r_hb_div <= r_hb_div + HB_W'(1);
                    end
                end
                DONE: begin
                    r_heartbeat <= 1'b1;
                end
                TIMEOUT: begin
                    // divider may carry a larger value over from RUN, hence >=
                    if (r_hb_div >= HB_FAST_LAST) begin
                        r_hb_div    <= '0;
                        r_heartbeat <= ~r_heartbeat;
                    end else begin
                        r_hb_div <= r_hb_div + HB_W'(1);
                    end
                end
                default: begin
                    r_heartbeat <= 1'b0;
                end
            endcase
        end
    end

    assign heartbeat = r_heartbeat;
`else
    assign heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_run_monitor.sv
// Directed self-checking bench for run_monitor (N_CH=2, CNT_W=4, MAX_CYCLES=100).
module tb_run_monitor;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CYC_W = 24;
    localparam int unsigned HOLDC = 16;
    localparam int unsigned MAXC  = 100;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       event_i;
    logic [N_CH*CNT_W-1:0] target_i;
    logic                  dut_reset;
    logic                  running;
    logic                  done;
    logic                  timeout;
    logic [CYC_W-1:0]      cycle_count;
    logic [N_CH*CNT_W-1:0] event_count;
    logic [N_CH-1:0]       chan_done;
    logic                  heartbeat;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Event pattern for the DONE test, bit1 = ch1, bit0 = ch0.
    logic [1:0] pat [9] = '{2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10};

    run_monitor #(
        .N_CH          (N_CH),
        .CNT_W         (CNT_W),
        .CYC_W         (CYC_W),
        .HOLD_CYCLES   (HOLDC),
        .MAX_CYCLES    (MAXC),
        .HEARTBEAT_DIV (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .event_i     (event_i),
        .target_i    (target_i),
        .dut_reset   (dut_reset),
        .running     (running),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .event_count (event_count),
        .chan_done   (chan_done),
        .heartbeat   (heartbeat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One edge with reset high, then reset released.
    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // dut_reset must stay high for 15 edges and fall with running rising on the 16th.
    task automatic hold_seq(input string tag);
        for (int k = 1; k <= int'(HOLDC); k++) begin
            tick();
            if (k < int'(HOLDC)) begin
                check({tag, "_hold_dut_reset"}, 32'(dut_reset), 32'd1);
            end else begin
                check({tag, "_rel_dut_reset"}, 32'(dut_reset), 32'd0);
                check({tag, "_rel_running"}, 32'(running), 32'd1);
                check({tag, "_rel_cycle"}, 32'(cycle_count), 32'd0);
            end
        end
    endtask

    initial begin
        // Reset state
        reset    = 1'b1;
        event_i  = '0;
        target_i = 8'h53;
        tick();
        tick();
        check("rst_dut_reset", 32'(dut_reset), 32'd1);
        check("rst_running", 32'(running), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_cycle", 32'(cycle_count), 32'd0);
        check("rst_events", 32'(event_count), 32'd0);
        check("rst_chan_done", 32'(chan_done), 32'd0);
        check("rst_heartbeat", 32'(heartbeat), 32'd0);

        // Targets {3,5} reached on cycle 9
        reset = 1'b0;
        hold_seq("t2");
        for (int c = 0; c < 8; c++) begin
            event_i = pat[c];
            tick();
        end
        check("t2_mid_cycle", 32'(cycle_count), 32'd8);
        check("t2_mid_events", 32'(event_count), 32'h43);
        check("t2_mid_chan_done", 32'(chan_done), 32'd1);
        check("t2_mid_done", 32'(done), 32'd0);
        event_i = pat[8];
        tick();
        check("t2_done", 32'(done), 32'd1);
        check("t2_timeout", 32'(timeout), 32'd0);
        check("t2_running", 32'(running), 32'd0);
        check("t2_cycle", 32'(cycle_count), 32'd9);
        check("t2_events", 32'(event_count), 32'h53);
        check("t2_chan_done", 32'(chan_done), 32'd3);
        check("t2_dut_reset", 32'(dut_reset), 32'd0);
        event_i = 2'b11;
        repeat (5) tick();
        event_i = '0;
        check("t2_frz_events", 32'(event_count), 32'h53);
        check("t2_frz_cycle", 32'(cycle_count), 32'd9);
        check("t2_frz_done", 32'(done), 32'd1);

        // Timeout: targets {1,1}, only ch0 pulses
        target_i = 8'h11;
        apply_reset();
        check("t3_rst_dut_reset", 32'(dut_reset), 32'd1);
        check("t3_rst_done", 32'(done), 32'd0);
        check("t3_rst_events", 32'(event_count), 32'd0);
        hold_seq("t3");
        event_i = 2'b01;
        tick();
        event_i = '0;
        repeat (98) tick();
        check("t3_pre_cycle", 32'(cycle_count), 32'd99);
        check("t3_pre_running", 32'(running), 32'd1);
        check("t3_pre_timeout", 32'(timeout), 32'd0);
        check("t3_pre_chan_done", 32'(chan_done), 32'd1);
        check("t3_pre_events", 32'(event_count), 32'h01);
        tick();
        check("t3_timeout", 32'(timeout), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_running", 32'(running), 32'd0);
        check("t3_cycle", 32'(cycle_count), 32'd100);
        repeat (3) tick();
        check("t3_frz_cycle", 32'(cycle_count), 32'd100);
        check("t3_frz_timeout", 32'(timeout), 32'd1);

        // Last event on cycle 100: DONE beats TIMEOUT
        apply_reset();
        hold_seq("t4");
        event_i = 2'b01;
        tick();
        event_i = '0;
        repeat (98) tick();
        check("t4_pre_running", 32'(running), 32'd1);
        event_i = 2'b10;
        tick();
        event_i = '0;
        check("t4_done", 32'(done), 32'd1);
        check("t4_timeout", 32'(timeout), 32'd0);
        check("t4_cycle", 32'(cycle_count), 32'd100);
        check("t4_events", 32'(event_count), 32'h11);
        check("t4_running", 32'(running), 32'd0);

        // Saturation of a 4-bit counter, then reset at run cycle 50
        target_i = 8'hFF;
        apply_reset();
        hold_seq("t5");
        event_i = 2'b01;
        repeat (15) tick();
        check("t5_c15_events", 32'(event_count), 32'h0F);
        check("t5_c15_chan_done", 32'(chan_done), 32'd1);
        tick();
        check("t5_c16_events", 32'(event_count), 32'h0F);
        repeat (24) tick();
        event_i = '0;
        check("t5_c40_events", 32'(event_count), 32'h0F);
        check("t5_c40_cycle", 32'(cycle_count), 32'd40);
        check("t5_c40_running", 32'(running), 32'd1);
        repeat (10) tick();
        check("t6_c50_cycle", 32'(cycle_count), 32'd50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_dut_reset", 32'(dut_reset), 32'd1);
        check("t6_running", 32'(running), 32'd0);
        check("t6_cycle", 32'(cycle_count), 32'd0);
        check("t6_events", 32'(event_count), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_timeout", 32'(timeout), 32'd0);
        hold_seq("t6");

        // All-zero targets: DONE on the first RUN edge
        target_i = '0;
        apply_reset();
        check("t7_hold_chan_done", 32'(chan_done), 32'd3);
        hold_seq("t7");
        check("t7_rel_done", 32'(done), 32'd0);
        tick();
        check("t7_done", 32'(done), 32'd1);
        check("t7_cycle", 32'(cycle_count), 32'd1);
        check("t7_running", 32'(running), 32'd0);
        check("t7_timeout", 32'(timeout), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
